// File: rtl/feedback_loop_decoder.sv
// Rebuilds r[n] = r[n-1] + d[n] from the encoder's difference stream, restarting at each frame sync.
// Latency: one cycle from the input accept to the output FIFO head, with no combinational path in->out.
// Backpressure: in_ready drops only when the output FIFO is full; out_data/out_sync hold while stalled.
module feedback_loop_decoder #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN  = 16
) (
  input  logic                     system1000,
  input  logic                     system1000_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_sync,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sync,
  output logic                     err_desync,
  input  logic                     err_clr,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);
  localparam logic [AW:0]   DEPTH_C     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {WAIT_SYNC, RUN} state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [DATA_W-1:0] r_acc, w_acc_nxt;
  logic [CW-1:0]            r_frame_cnt, w_frame_cnt_nxt;
  logic                     w_accept, w_push, w_push_sync, w_drop, w_err_set;

  // Output FIFO storage: each entry is {sync, sample}.
  logic [DATA_W:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [AW:0]              r_count;
  logic                     w_full, w_pop;

  assign w_full   = (r_count == DEPTH_C);
  assign w_pop    = out_valid && out_ready;
  assign in_ready = !w_full && !system1000_rst;
  assign w_accept = in_valid && in_ready;

  assign out_valid = (r_count != '0);
  // Gated to zero when empty so stale entries from before a reset never show.
  assign {out_sync, out_data} = out_valid ? r_mem[r_rd_ptr] : '0;

  // Framing FSM and accumulator: decide next state, push/drop, and error set.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_frame_cnt_nxt = r_frame_cnt;
    w_push          = 1'b0;
    w_push_sync     = 1'b0;
    w_drop          = 1'b0;
    w_err_set       = 1'b0;
    if (w_accept) begin
      case (r_state)
        WAIT_SYNC: begin
          if (in_sync) begin
            w_acc_nxt       = in_data;
            w_push          = 1'b1;
            w_push_sync     = 1'b1;
            w_frame_cnt_nxt = CW'(1);
            w_state_nxt     = RUN;
          end else begin
            w_drop = 1'b1;
          end
        end
        RUN: begin
          if (in_sync) begin
            // A sync before the frame is complete is flagged but still honoured.
            w_err_set       = (r_frame_cnt < FRAME_LEN_C);
            w_acc_nxt       = in_data;
            w_push          = 1'b1;
            w_push_sync     = 1'b1;
            w_frame_cnt_nxt = CW'(1);
          end else if (r_frame_cnt < FRAME_LEN_C) begin
            w_acc_nxt       = r_acc + in_data;
            w_push          = 1'b1;
            w_frame_cnt_nxt = r_frame_cnt + CW'(1);
          end else begin
            // Frame over-ran without a sync: lose lock and hunt again.
            w_err_set   = 1'b1;
            w_drop      = 1'b1;
            w_state_nxt = WAIT_SYNC;
          end
        end
        default: w_state_nxt = WAIT_SYNC;
      endcase
    end
  end

  // State, accumulator and frame counter registers.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      r_state     <= WAIT_SYNC;
      r_acc       <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  // FIFO pointers and occupancy; reset empties the queue outright.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // FIFO storage write; push is impossible during reset since in_ready is low.
  always_ff @(posedge system1000) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_push_sync, w_acc_nxt};
  end

  // Sticky desync flag (set beats clear) and saturating drop counter.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      err_desync <= 1'b0;
      drop_count <= '0;
    end else begin
      if (w_err_set)    err_desync <= 1'b1;
      else if (err_clr) err_desync <= 1'b0;
      if (w_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_feedback_loop_decoder.sv
// Directed checks of the feedback-loop decoder: reconstruction, wrap, framing errors, backpressure, reset.
// Inputs change 1 time unit after a rising edge; outputs are read before and after each edge.
// Out_ready backpressure is exercised in the hand-written sequences at the end.
module tb_feedback_loop_decoder;

  logic              system1000 = 1'b0;
  logic              system1000_rst;
  logic              in_valid, in_ready, in_sync;
  logic signed [7:0] in_data;
  logic              out_valid, out_ready, out_sync;
  logic signed [7:0] out_data;
  logic              err_desync, err_clr;
  logic [7:0]        drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  feedback_loop_decoder #(.DATA_W(8), .FIFO_DEPTH(4), .FRAME_LEN(16)) dut (
    .system1000     (system1000),
    .system1000_rst (system1000_rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_sync        (in_sync),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sync       (out_sync),
    .err_desync     (err_desync),
    .err_clr        (err_clr),
    .drop_count     (drop_count)
  );

  always #5 system1000 = ~system1000;

  typedef struct {
    logic              rst, vld, sync, clr;
    logic signed [7:0] d;
    logic              exp_irdy, exp_ov;
    logic signed [7:0] exp_od;
    logic              exp_os, exp_err;
    logic [7:0]        exp_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic vld, input logic sync, input logic clr,
                     input int d, input logic exp_ov, input int exp_od, input logic exp_os,
                     input logic exp_err, input int exp_drop);
    vec_t v;
    v.rst = rst; v.vld = vld; v.sync = sync; v.clr = clr;
    v.d = d[7:0];
    v.exp_irdy = !rst;
    v.exp_ov = exp_ov; v.exp_od = exp_od[7:0]; v.exp_os = exp_os;
    v.exp_err = exp_err; v.exp_drop = exp_drop[7:0];
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge system1000);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx, got;
    logic acc;
    int   bp_d [6];
    bp_d = '{10, 1, 1, 1, 1, 1};

    system1000_rst = 1'b1;
    in_valid = 1'b0; in_sync = 1'b0; in_data = '0;
    out_ready = 1'b1; err_clr = 1'b0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sync", out_sync, 0);
    chk("rst_err", err_desync, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_in_ready", in_ready, 0);

    // Basic reconstruction: 5, 8, 6, -4.
    add(0,1,1,0,   5, 1,   5,1,0,0);
    add(0,1,0,0,   3, 1,   8,0,0,0);
    add(0,1,0,0,  -2, 1,   6,0,0,0);
    add(0,1,0,0, -10, 1,  -4,0,0,0);
    add(1,0,0,0,   0, 0,   0,0,0,0);
    add(0,0,0,0,   0, 0,   0,0,0,0);
    // Wrap-around modulo 256.
    add(0,1,1,0, 100, 1, 100,1,0,0);
    add(0,1,0,0, 100, 1, -56,0,0,0);
    add(0,1,0,0, 100, 1,  44,0,0,0);
    add(1,0,0,0,   0, 0,   0,0,0,0);
    // Pre-sync drops, then lock on 7.
    add(0,1,0,0,   1, 0,   0,0,0,1);
    add(0,1,0,0,   2, 0,   0,0,0,2);
    add(0,1,0,0,   3, 0,   0,0,0,3);
    add(0,1,1,0,   7, 1,   7,1,0,3);
    for (int k = 1; k <= 8; k++) add(0,1,0,0, 1, 1, 7+k, 0,0,3);
    // Early sync on the 10th sample of the frame.
    add(0,1,1,0,  -3, 1,  -3,1,1,3);
    add(0,0,0,1,   0, 0,   0,0,0,3);
    for (int k = 1; k <= 15; k++) add(0,1,0,0, 2, 1, -3+2*k, 0,0,3);
    // Missing sync on the 17th sample, then still hunting.
    add(0,1,0,0,   9, 0,   0,0,1,4);
    add(0,1,0,0,   5, 0,   0,0,1,5);
    add(0,1,1,0,   4, 1,   4,1,1,5);
    // Early sync together with clear: set wins.
    add(0,1,1,1,   1, 1,   1,1,1,5);
    add(0,0,0,1,   0, 0,   0,0,0,5);

    foreach (vecs[i]) begin
      system1000_rst = vecs[i].rst;
      in_valid = vecs[i].vld; in_sync = vecs[i].sync; in_data = vecs[i].d;
      err_clr = vecs[i].clr; out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].exp_irdy);
      @(posedge system1000);
      #1;
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      if (vecs[i].exp_ov) begin
        chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_od);
        chk($sformatf("v%0d_out_sync", i), out_sync, vecs[i].exp_os);
      end
      chk($sformatf("v%0d_err", i), err_desync, vecs[i].exp_err);
      chk($sformatf("v%0d_drop", i), drop_count, vecs[i].exp_drop);
    end
    in_valid = 1'b0; err_clr = 1'b0;

    // Backpressure: six samples offered into a 4-deep FIFO with out_ready low.
    system1000_rst = 1'b1; tick(); system1000_rst = 1'b0;
    out_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1'b1; in_data = bp_d[idx]; in_sync = (idx == 0);
      #1;
      chk($sformatf("bp_in_ready_c%0d", cyc), in_ready, (cyc < 4) ? 1 : 0);
      acc = in_valid && in_ready;
      @(posedge system1000); #1;
      if (acc) idx++;
      chk($sformatf("bp_head_hold_c%0d", cyc), out_data, 10);
    end
    chk("bp_accepted", idx, 4);
    chk("bp_full_ready", in_ready, 0);

    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      in_valid = (idx < 6);
      in_data  = (idx < 6) ? bp_d[idx] : 8'sd0;
      in_sync  = 1'b0;
      #1;
      if (cyc == 0) chk("bp_ready_lags_pop", in_ready, 0);
      if (out_valid && out_ready) begin
        chk($sformatf("bp_out_data_%0d", got), out_data, 10 + got);
        chk($sformatf("bp_out_sync_%0d", got), out_sync, (got == 0) ? 1 : 0);
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge system1000); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_outputs_seen", got, 6);
    chk("bp_all_accepted", idx, 6);
    tick();
    chk("bp_no_duplicate", out_valid, 0);

    // Reset mid-frame with three samples buffered.
    system1000_rst = 1'b1; tick(); system1000_rst = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_sync = 1'b0; in_data = 8'sd9; tick();
    in_sync = 1'b1; in_data = 8'sd20; tick();
    in_sync = 1'b0; in_data = 8'sd1;  tick();
    in_data = 8'sd2; tick();
    in_valid = 1'b0;
    chk("mid_buffered_valid", out_valid, 1);
    chk("mid_pre_drop", drop_count, 1);
    system1000_rst = 1'b1;
    #1;
    chk("mid_in_ready_rst", in_ready, 0);
    @(posedge system1000); #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_drop", drop_count, 0);
    system1000_rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_sync = 1'b0; in_data = 8'sd5;
    #1;
    chk("mid_in_ready_after", in_ready, 1);
    @(posedge system1000); #1;
    in_valid = 1'b0;
    chk("mid_first_dropped", drop_count, 1);
    chk("mid_no_output", out_valid, 0);
    tick();
    chk("mid_still_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
